// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM status, arbiter states, data word, starvation limit.
// Imported by mem_arbiter and its bench.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

    localparam logic [2:0] STARVE_LIMIT = 3'd4;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache; dcache has priority.
// Optional starvation guard for the icache: define ARB_STARVE_GUARD_EN.
module mem_arbiter
    import cpu_types_pkg::*;
(
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    arb_state_t state;
    arb_state_t next;
    logic       dreq;
    logic       starved;

    assign dreq  = dREN | dWEN;
    assign iload = ramload;
    assign dload = ramload;

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt;

    assign starved = (starve_cnt == STARVE_LIMIT);

    // Count dcache wins while the icache waits; saturate at the limit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (state == IACC && !iwait) begin
            starve_cnt <= '0;
        end else if (state == IDLE && !iREN) begin
            starve_cnt <= '0;
        end else if (state == DACC && !dwait && iREN && !starved) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    assign starved = 1'b0;
`endif

    // State register; reset abandons any access in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Grant selection, RAM steering and wait pulses.
    always_comb begin
        next     = state;
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        unique case (state)
            IDLE: begin
                if (dreq && !starved) begin
                    next = DACC;
                end else if (iREN) begin
                    next = IACC;
                end
            end
            IACC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (!iREN) begin
                    next = IDLE;
                end else if (ramstate == ACCESS) begin
                    iwait = 1'b0;
                    next  = IDLE;
                end
            end
            DACC: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!dreq) begin
                    next = IDLE;
                end else if (ramstate == ACCESS) begin
                    dwait = 1'b0;
                    next  = IDLE;
                end
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions are queued by the
// stimulus and consumed by a monitor whenever a wait line drops.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    typedef struct {
        bit    is_d;
        word_t data;
    } exp_t;

    logic      CLK;
    logic      nRST;
    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      iwait;
    logic      dwait;
    word_t     iload;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    int   errors;
    int   checks;
    int   n_i;
    int   n_d;
    exp_t expq[$];

    mem_arbiter dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input bit is_d, input word_t data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        expq.push_back(e);
    endtask

    // Monitor: every wait pulse must match the head of the expected queue.
    always @(negedge CLK) begin
        if (nRST && (!iwait || !dwait)) begin
            exp_t e;
            checks++;
            if (!iwait && !dwait) begin
                errors++;
                $display("FAIL both_wait_low: iwait=%b dwait=%b", iwait, dwait);
            end else if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: iwait=%b dwait=%b", iwait, dwait);
            end else begin
                e = expq.pop_front();
                if (e.is_d != !dwait) begin
                    errors++;
                    $display("FAIL pulse_owner: got d=%b expected d=%b", !dwait, e.is_d);
                end else if ((e.is_d ? dload : iload) !== e.data) begin
                    errors++;
                    $display("FAIL pulse_data: got %h expected %h",
                             e.is_d ? dload : iload, e.data);
                end
                if (!dwait) n_d++;
                if (!iwait) n_i++;
            end
        end
    end

    initial begin
        errors   = 0;
        checks   = 0;
        n_i      = 0;
        n_d      = 0;
        nRST     = 1'b0;
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        iaddr    = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = FREE;

        // reset state
        #3;
        chk("rst_iwait", {31'd0, iwait}, 32'd1);
        chk("rst_dwait", {31'd0, dwait}, 32'd1);
        chk("rst_ren", {31'd0, ramREN}, 32'd0);
        chk("rst_wen", {31'd0, ramWEN}, 32'd0);
        chk("rst_addr", ramaddr, 32'd0);
        chk("rst_store", ramstore, 32'd0);
        step();
        step();
        nRST = 1'b1;
        step();

        // simultaneous i/d read: dcache first, then icache
        iREN     = 1'b1;
        dREN     = 1'b1;
        iaddr    = 32'h100;
        daddr    = 32'h40;
        ramload  = 32'hDEADBEEF;
        ramstate = ACCESS;
        push(1'b1, 32'hDEADBEEF);
        push(1'b0, 32'hCAFEF00D);
        @(negedge CLK);
        chk("idle_ren", {31'd0, ramREN}, 32'd0);
        step();
        @(negedge CLK);
        chk("dacc_addr", ramaddr, 32'h40);
        chk("dacc_ren", {31'd0, ramREN}, 32'd1);
        chk("iload_eq_ramload", iload, 32'hDEADBEEF);
        step();
        dREN    = 1'b0;
        ramload = 32'hCAFEF00D;
        @(negedge CLK);
        chk("gap_idle_addr", ramaddr, 32'd0);
        chk("gap_idle_ren", {31'd0, ramREN}, 32'd0);
        step();
        @(negedge CLK);
        chk("iacc_addr", ramaddr, 32'h100);
        step();
        iREN = 1'b0;
        step();

        // write wins over read
        dWEN     = 1'b1;
        dREN     = 1'b1;
        daddr    = 32'h80;
        dstore   = 32'h1234;
        ramstate = BUSY;
        step();
        @(negedge CLK);
        chk("wr_wen", {31'd0, ramWEN}, 32'd1);
        chk("wr_ren", {31'd0, ramREN}, 32'd0);
        chk("wr_addr", ramaddr, 32'h80);
        chk("wr_store", ramstore, 32'h1234);
        chk("wr_busy_dwait", {31'd0, dwait}, 32'd1);
        step();
        ramload  = 32'h55AA55AA;
        ramstate = ACCESS;
        push(1'b1, 32'h55AA55AA);
        step();
        dWEN = 1'b0;
        dREN = 1'b0;
        step();

        // icache with 3 BUSY cycles then ACCESS
        iREN     = 1'b1;
        iaddr    = 32'h200;
        ramload  = 32'h0BADF00D;
        ramstate = BUSY;
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("busy_iwait", {31'd0, iwait}, 32'd1);
            step();
        end
        ramstate = ACCESS;
        push(1'b0, 32'h0BADF00D);
        step();
        iREN = 1'b0;
        @(negedge CLK);
        chk("pulse_one_cycle", {31'd0, iwait}, 32'd1);
        step();

        // ERROR retried until ACCESS
        dREN     = 1'b1;
        daddr    = 32'h44;
        ramload  = 32'h600DCAFE;
        ramstate = ERROR;
        step();
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            chk("err_dwait", {31'd0, dwait}, 32'd1);
            step();
        end
        ramstate = ACCESS;
        push(1'b1, 32'h600DCAFE);
        step();
        dREN = 1'b0;
        step();

        // owner withdraws mid-access: no pulse
        iREN     = 1'b1;
        ramstate = BUSY;
        step();
        step();
        iREN     = 1'b0;
        ramstate = ACCESS;
        @(negedge CLK);
        chk("withdraw_iwait", {31'd0, iwait}, 32'd1);
        step();
        @(negedge CLK);
        chk("withdraw_idle", {31'd0, ramREN}, 32'd0);
        step();

        // reset mid-DACC
        dREN     = 1'b1;
        daddr    = 32'h88;
        ramstate = BUSY;
        step();
        @(negedge CLK);
        chk("pre_rst_ren", {31'd0, ramREN}, 32'd1);
        step();
        #2;
        nRST = 1'b0;
        #1;
        chk("mid_rst_iwait", {31'd0, iwait}, 32'd1);
        chk("mid_rst_dwait", {31'd0, dwait}, 32'd1);
        chk("mid_rst_ren", {31'd0, ramREN}, 32'd0);
        chk("mid_rst_wen", {31'd0, ramWEN}, 32'd0);
        chk("mid_rst_addr", ramaddr, 32'd0);
        dREN     = 1'b0;
        ramstate = ACCESS;
        step();
        #2;
        nRST = 1'b1;
        step();
        @(negedge CLK);
        chk("post_rst_idle", ramaddr, 32'd0);
        chk("post_rst_dwait", {31'd0, dwait}, 32'd1);
        step();

        // continuous contention
        n_i      = 0;
        n_d      = 0;
        iREN     = 1'b1;
        dREN     = 1'b1;
        ramload  = 32'h13572468;
        ramstate = ACCESS;
        for (int k = 0; k < 20; k++) begin
`ifdef ARB_STARVE_GUARD_EN
            push((k % 5) != 4, 32'h13572468);
`else
            push(1'b1, 32'h13572468);
`endif
        end
        for (int k = 0; k < 40; k++) step();
        iREN = 1'b0;
        dREN = 1'b0;
        step();
        step();
`ifdef ARB_STARVE_GUARD_EN
        chk("starve_i_count", n_i, 32'd4);
        chk("starve_d_count", n_d, 32'd16);
`else
        chk("strict_i_count", n_i, 32'd0);
        chk("strict_d_count", n_d, 32'd20);
`endif
        chk("queue_drained", expq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
